// File: rtl/mem_pkg.sv
// Shared types and constants for the 256x8 data memory and its block mover.
// Imported by every block that talks to the data memory port.
package mem_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } mover_state_t;

  typedef enum logic {
    FWD,
    BWD
  } mover_dir_t;

endpackage

// File: rtl/mem_block_mover.sv
// Block copy engine for the data memory: one read cycle then one write
// cycle per byte, copying backward when the ranges overlap destructively.
module mem_block_mover
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] ONE = AW'(1);

  mover_state_t  state;
  mover_dir_t    dir;
  logic [AW-1:0] cur_src;
  logic [AW-1:0] cur_dst;
  logic [AW-1:0] cnt;
  logic [DW-1:0] hold;

  logic [AW:0]   src_x;
  logic [AW:0]   end_x;
  logic [AW:0]   dst_x;
  logic          go_bwd;

  // Overlap test is done unwrapped on AW+1 bits.
  always_comb begin
    src_x  = {1'b0, src};
    dst_x  = {1'b0, dst};
    end_x  = src_x + {1'b0, len};
    go_bwd = (dst_x > src_x) && (dst_x < end_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir     <= FWD;
      cur_src <= '0;
      cur_dst <= '0;
      cnt     <= '0;
      hold    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt <= len;
            if (go_bwd) begin
              dir     <= BWD;
              cur_src <= src + len - ONE;
              cur_dst <= dst + len - ONE;
            end else begin
              dir     <= FWD;
              cur_src <= src;
              cur_dst <= dst;
            end
            state <= (len == '0) ? DONE : RD;
          end
        end
        RD: begin
          hold  <= mem_rdata;
          state <= WR;
        end
        WR: begin
          if (dir == BWD) begin
            cur_src <= cur_src - ONE;
            cur_dst <= cur_dst - ONE;
          end else begin
            cur_src <= cur_src + ONE;
            cur_dst <= cur_dst + ONE;
          end
          cnt   <= cnt - ONE;
          state <= (cnt == ONE) ? DONE : RD;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_wr_en = (state == WR);
    mem_wdata = hold;
    mem_addr  = '0;
    unique case (state)
      RD:      mem_addr = cur_src;
      WR:      mem_addr = cur_dst;
      default: mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench: mover plus a 256x8 memory behind a core/mover mux,
// compared against a byte-by-byte copy model.
module tb_mem_block_mover;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_data;
  logic [7:0] m_addr;
  logic       m_we;
  logic [7:0] m_wd;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  mem_block_mover dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_addr    = busy ? mem_addr  : core_addr;
  assign m_we      = busy ? mem_wr_en : core_we;
  assign m_wd      = busy ? mem_wdata : core_data;
  assign mem_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wd;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input int v);
    @(negedge clk);
    core_we   = 1'b1;
    core_addr = 8'(a);
    core_data = 8'(v);
    ref_mem[a & 255] = 8'(v);
    @(negedge clk);
    core_we = 1'b0;
  endtask

  // Byte-at-a-time copy in the chosen direction, addresses mod 256.
  task automatic model_copy(input int s, input int d, input int l);
    bit bwd;
    int sa;
    int da;
    bwd = (d > s) && (d < s + l);
    for (int i = 0; i < l; i++) begin
      if (bwd) begin
        sa = (s + l - 1 - i) & 255;
        da = (d + l - 1 - i) & 255;
      end else begin
        sa = (s + i) & 255;
        da = (d + i) & 255;
      end
      ref_mem[da] = ref_mem[sa];
    end
  endtask

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic run_copy(
    input  int s, input int d, input int l, input int intr,
    output int lat, output int wrs, output int consec, output int extra
  );
    bit prev;
    @(negedge clk);
    start = 1'b1;
    src   = 8'(s);
    dst   = 8'(d);
    len   = 8'(l);
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    wrs    = 0;
    consec = 0;
    extra  = 0;
    prev   = 1'b0;
    for (int k = 1; k < 600; k++) begin
      if (k == intr) begin
        start = 1'b1;
        src   = 8'd0;
        dst   = 8'd100;
        len   = 8'd1;
      end
      if (k == intr + 1) start = 1'b0;
      if (mem_wr_en) begin
        wrs++;
        if (prev) consec++;
      end
      prev = mem_wr_en;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy || done || mem_wr_en) extra++;
    end
  endtask

  task automatic copy_and_check(
    input string tag, input int s, input int d, input int l, input int intr
  );
    int lat;
    int wrs;
    int consec;
    int extra;
    model_copy(s, d, l);
    run_copy(s, d, l, intr, lat, wrs, consec, extra);
    check({tag, " latency"}, lat, (l == 0) ? 1 : 2 * l + 1);
    check({tag, " writes"}, wrs, l);
    check({tag, " wr_en back-to-back"}, consec, 0);
    check({tag, " idle after done"}, extra, 0);
    check({tag, " mem diffs"}, mem_diffs(), 0);
  endtask

  initial begin
    int s;
    int d;
    int l;
    int wrs;
    bit hit;
    rst_n     = 1'b0;
    start     = 1'b0;
    src       = '0;
    dst       = '0;
    len       = '0;
    core_we   = 1'b0;
    core_addr = '0;
    core_data = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wr_en", mem_wr_en, 0);
    check("reset addr", mem_addr, 0);
    check("reset wdata", mem_wdata, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) poke(i, $urandom_range(0, 255));
    check("preload", mem_diffs(), 0);

    poke(10, 11); poke(11, 22); poke(12, 33); poke(13, 44);
    copy_and_check("t1", 10, 40, 4, 0);
    check("t1 mem[43]", mem[43], 44);

    poke(20, 1); poke(21, 2); poke(22, 3); poke(23, 4);
    copy_and_check("t2 overlap", 20, 21, 4, 0);
    check("t2 mem[24]", mem[24], 4);
    check("t2 mem[20]", mem[20], 1);

    poke(254, 8'hA); poke(255, 8'hB); poke(0, 8'hC);
    copy_and_check("t3 wrap", 254, 128, 3, 0);
    check("t3 mem[82]", mem[8'h82], 8'hC);

    copy_and_check("t4 len0", 5, 6, 0, 0);

    poke(50, 7); poke(51, 8); poke(52, 9);
    copy_and_check("t5 start busy", 50, 60, 3, 2);

    copy_and_check("src eq dst", 30, 30, 6, 0);

    // Reset lands in the RD cycle after the second write.
    for (int i = 0; i < 5; i++) poke(70 + i, $urandom_range(0, 255));
    @(negedge clk);
    start = 1'b1;
    src   = 8'd70;
    dst   = 8'd90;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wrs   = 0;
    hit   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_wr_en) wrs++;
      if (wrs == 2 && mem_wr_en) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6 reached 2 writes", hit, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6 busy", busy, 0);
    check("t6 done", done, 0);
    check("t6 wr_en", mem_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 no done", done, 0);
    model_copy(70, 90, 2);
    check("t6 mem diffs", mem_diffs(), 0);
    copy_and_check("t6 restart", 70, 90, 5, 0);

    for (int it = 0; it < 25; it++) begin
      s = $urandom_range(0, 255);
      l = $urandom_range(0, 24);
      if ($urandom_range(0, 2) == 0) d = (s + $urandom_range(0, 8)) & 255;
      else if ($urandom_range(0, 1) == 0) d = (s - $urandom_range(1, 8)) & 255;
      else d = $urandom_range(0, 255);
      copy_and_check($sformatf("rand%0d", it), s, d, l, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
